csr_access_controller: RTL and testbench

//  Core-side CSR sequencer: takes one decoded Zicsr instruction, drives the shared CSR read bus, then the write bus.

---
 rtl/csr_pkg.sv | 32 +++
 rtl/csr_write_value.sv | 21 ++
 rtl/csr_access_controller.sv | 172 +++++++++++++++++
 tb/tb_csr_access_controller.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the CSR access sequencer: funct3 encodings, FSM states
// and the address fields that carry read-only and privilege information.
package csr_pkg;

    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    // funct3[1:0] selects the merge; funct3[2] selects the immediate operand.
    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_RW   = 2'b01;
    localparam logic [1:0] MODE_RS   = 2'b10;
    localparam logic [1:0] MODE_RC   = 2'b11;

    localparam int RO_HI   = 11;
    localparam int RO_LO   = 10;
    localparam int PRIV_HI = 9;
    localparam int PRIV_LO = 8;

    localparam logic [1:0] RO_TAG = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } csr_state_e;

endpackage

// File: rtl/csr_write_value.sv
// Combinational merge of the old CSR value with the operand for the
// read-write, read-set and read-clear instruction forms.
module csr_write_value
    import csr_pkg::*;
(
    input  logic [1:0]  mode_i,
    input  logic [31:0] old_i,
    input  logic [31:0] operand_i,
    output logic [31:0] new_o
);

    always_comb begin
        new_o = operand_i;
        case (mode_i)
            MODE_RS: new_o = old_i | operand_i;
            MODE_RC: new_o = old_i & ~operand_i;
            default: new_o = operand_i;
        endcase
    end

endmodule

// File: rtl/csr_access_controller.sv
// Core-side CSR sequencer: IDLE -> READ -> WRITE -> DONE for one Zicsr instruction.
// Optional build macro CSR_PRIV_CHECK_EN adds currentPrivilege and an address privilege check.
module csr_access_controller
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        instrValid,
    output logic        instrReady,
    input  logic [2:0]  instrFunct3,
    input  logic [11:0] instrAddress,
    input  logic [31:0] instrOperand,
    input  logic [4:0]  instrRs1,
    input  logic [4:0]  instrRd,
    output logic        csrReadEnable,
    output logic [11:0] csrReadAddress,
    input  logic [31:0] csrReadData,
    input  logic        csrReadRequest,
    output logic        csrWriteEnable,
    output logic [11:0] csrWriteAddress,
    output logic [31:0] csrWriteData,
    input  logic        csrWriteRequest,
    output logic        resultValid,
    input  logic        resultReady,
    output logic [31:0] resultData,
`ifdef CSR_PRIV_CHECK_EN
    input  logic [1:0]  currentPrivilege,
`endif
    output logic        resultIllegal
);

    // Handshakes: a transfer happens on a clock edge where valid and ready are both 1.
    // instrReady is 1 only in IDLE; resultValid holds with stable data until resultReady.

    csr_state_e  state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] op_q, op_d;
    logic [31:0] old_q, old_d;
    logic        do_read_q, do_read_d;
    logic        do_write_q, do_write_d;
    logic        illegal_q, illegal_d;
    logic [31:0] write_value;
    logic        instr_is_rw;

    csr_write_value u_write_value (
        .mode_i    (mode_q),
        .old_i     (old_q),
        .operand_i (op_q),
        .new_o     (write_value)
    );

    assign instr_is_rw = (instrFunct3[1:0] == MODE_RW);

    always_comb begin
        state_d         = state_q;
        mode_d          = mode_q;
        addr_d          = addr_q;
        op_d            = op_q;
        old_d           = old_q;
        do_read_d       = do_read_q;
        do_write_d      = do_write_q;
        illegal_d       = illegal_q;
        instrReady      = 1'b0;
        csrReadEnable   = 1'b0;
        csrReadAddress  = 12'h000;
        csrWriteEnable  = 1'b0;
        csrWriteAddress = 12'h000;
        csrWriteData    = 32'h0;
        resultValid     = 1'b0;
        resultData      = 32'h0;
        resultIllegal   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                instrReady = 1'b1;
                if (instrValid) begin
                    mode_d     = instrFunct3[1:0];
                    addr_d     = instrAddress;
                    op_d       = instrFunct3[2] ? {27'd0, instrRs1} : instrOperand;
                    do_read_d  = !(instr_is_rw && (instrRd == 5'd0));
                    do_write_d = instr_is_rw || (instrRs1 != 5'd0);
                    old_d      = 32'h0;
                    illegal_d  = 1'b0;
                    state_d    = ST_READ;
                    if (instrFunct3[1:0] == MODE_NONE) begin
                        illegal_d = 1'b1;
                        state_d   = ST_DONE;
                    end
`ifdef CSR_PRIV_CHECK_EN
                    else if (instrAddress[PRIV_HI:PRIV_LO] > currentPrivilege) begin
                        illegal_d = 1'b1;
                        state_d   = ST_DONE;
                    end
`endif
                end
            end
            ST_READ: begin
                csrReadEnable  = do_read_q;
                csrReadAddress = addr_q;
                // A suppressed read behaves as an old value of zero for the merge.
                old_d          = do_read_q ? csrReadData : 32'h0;
                if (do_read_q && !csrReadRequest) begin
                    illegal_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (do_write_q) begin
                    if (addr_q[RO_HI:RO_LO] == RO_TAG) begin
                        illegal_d = 1'b1;
                    end else begin
                        csrWriteEnable  = 1'b1;
                        csrWriteAddress = addr_q;
                        csrWriteData    = write_value;
                        if (!csrWriteRequest) begin
                            illegal_d = 1'b1;
                        end
                    end
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                resultValid   = 1'b1;
                resultData    = illegal_q ? 32'h0 : old_q;
                resultIllegal = illegal_q;
                if (resultReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Reset silences every output in the same cycle so no strobe escapes.
        if (!rst) begin
            instrReady      = 1'b1;
            csrReadEnable   = 1'b0;
            csrReadAddress  = 12'h000;
            csrWriteEnable  = 1'b0;
            csrWriteAddress = 12'h000;
            csrWriteData    = 32'h0;
            resultValid     = 1'b0;
            resultData      = 32'h0;
            resultIllegal   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_NONE;
            addr_q     <= 12'h000;
            op_q       <= 32'h0;
            old_q      <= 32'h0;
            do_read_q  <= 1'b0;
            do_write_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            addr_q     <= addr_d;
            op_q       <= op_d;
            old_q      <= old_d;
            do_read_q  <= do_read_d;
            do_write_q <= do_write_d;
            illegal_q  <= illegal_d;
        end
    end

endmodule

// File: tb/tb_csr_access_controller.sv
// Self-checking bench for csr_access_controller: directed scenarios plus random
// instructions against a rule-level model of the expected bus and result behaviour.
module tb_csr_access_controller;

    logic        clk;
    logic        rst;
    logic        instrValid;
    logic        instrReady;
    logic [2:0]  instrFunct3;
    logic [11:0] instrAddress;
    logic [31:0] instrOperand;
    logic [4:0]  instrRs1;
    logic [4:0]  instrRd;
    logic        csrReadEnable;
    logic [11:0] csrReadAddress;
    logic [31:0] csrReadData;
    logic        csrReadRequest;
    logic        csrWriteEnable;
    logic [11:0] csrWriteAddress;
    logic [31:0] csrWriteData;
    logic        csrWriteRequest;
    logic        resultValid;
    logic        resultReady;
    logic [31:0] resultData;
    logic        resultIllegal;
`ifdef CSR_PRIV_CHECK_EN
    logic [1:0]  currentPrivilege;
`endif

    logic [31:0] bus_rd_val;
    logic        bus_claim;
    logic        bus_accept;

    int n_checks;
    int n_errors;
    logic [31:0] exp_q[$];

    csr_access_controller dut (
        .clk             (clk),
        .rst             (rst),
        .instrValid      (instrValid),
        .instrReady      (instrReady),
        .instrFunct3     (instrFunct3),
        .instrAddress    (instrAddress),
        .instrOperand    (instrOperand),
        .instrRs1        (instrRs1),
        .instrRd         (instrRd),
        .csrReadEnable   (csrReadEnable),
        .csrReadAddress  (csrReadAddress),
        .csrReadData     (csrReadData),
        .csrReadRequest  (csrReadRequest),
        .csrWriteEnable  (csrWriteEnable),
        .csrWriteAddress (csrWriteAddress),
        .csrWriteData    (csrWriteData),
        .csrWriteRequest (csrWriteRequest),
        .resultValid     (resultValid),
        .resultReady     (resultReady),
        .resultData      (resultData),
`ifdef CSR_PRIV_CHECK_EN
        .currentPrivilege(currentPrivilege),
`endif
        .resultIllegal   (resultIllegal)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus model: one addressed register answers only while strobed.
    assign csrReadData     = (csrReadEnable && bus_claim) ? bus_rd_val : 32'h0;
    assign csrReadRequest  = csrReadEnable && bus_claim;
    assign csrWriteRequest = csrWriteEnable && bus_accept;

    task automatic run_instr(input string name, input logic [2:0] f3, input logic [11:0] addr,
                             input logic [31:0] op, input logic [4:0] rs1, input logic [4:0] rd,
                             input logic [31:0] rval, input logic claim, input logic accept,
                             input int dly);
        logic is_w, do_rd, do_wr, e_ill, seen;
        logic [31:0] opv, old, wv, got, e_res, hold_d;
        logic hold_i;
        int e_lat, e_rd, e_wr, k, rd_cnt, wr_cnt, res_k, wr_k;
        is_w  = (f3[1:0] == 2'b01);
        opv   = f3[2] ? {27'd0, rs1} : op;
        do_rd = !(is_w && rd == 5'd0);
        do_wr = is_w || (rs1 != 5'd0);
        e_ill = 1'b0; e_rd = 0; e_wr = 0; e_res = 32'h0; e_lat = 3; old = 32'h0;
        exp_q.delete();
        if (f3[1:0] == 2'b00) begin
            e_ill = 1'b1; e_lat = 1;
        end
`ifdef CSR_PRIV_CHECK_EN
        else if (addr[9:8] > currentPrivilege) begin
            e_ill = 1'b1; e_lat = 1;
        end
`endif
        else begin
            e_rd = do_rd ? 1 : 0;
            if (do_rd && !claim) begin
                e_ill = 1'b1; e_lat = 2;
            end else begin
                old = do_rd ? rval : 32'h0;
                if (do_wr) begin
                    if (addr[11:10] == 2'b11) begin
                        e_ill = 1'b1;
                    end else begin
                        case (f3[1:0])
                            2'b01:   wv = opv;
                            2'b10:   wv = old | opv;
                            default: wv = old & ~opv;
                        endcase
                        e_wr = 1;
                        exp_q.push_back(wv);
                        if (!accept) e_ill = 1'b1;
                    end
                end
                if (!e_ill) e_res = old;
            end
        end

        // Drive
        bus_rd_val = rval; bus_claim = claim; bus_accept = accept;
        n_checks++;
        if (instrReady !== 1'b1) begin
            n_errors++; $display("FAIL %s accept_ready got %b exp 1", name, instrReady);
        end
        instrValid = 1'b1; instrFunct3 = f3; instrAddress = addr;
        instrOperand = op; instrRs1 = rs1; instrRd = rd;

        k = 0; seen = 1'b0; rd_cnt = 0; wr_cnt = 0; res_k = -1; wr_k = -1;
        while (!seen && k < 10) begin
            @(negedge clk);
            k++;
            if (csrReadEnable) begin
                rd_cnt++;
                n_checks++;
                if (csrReadAddress !== addr) begin
                    n_errors++; $display("FAIL %s read_addr got %h exp %h", name, csrReadAddress, addr);
                end
                n_checks++;
                if (k != 1) begin
                    n_errors++; $display("FAIL %s read_cycle got %0d exp 1", name, k);
                end
            end
            if (csrWriteEnable) begin
                wr_cnt++; wr_k = k;
                n_checks++;
                if (csrWriteAddress !== addr) begin
                    n_errors++; $display("FAIL %s write_addr got %h exp %h", name, csrWriteAddress, addr);
                end
                if (exp_q.size() > 0) begin
                    got = exp_q.pop_front();
                    n_checks++;
                    if (csrWriteData !== got) begin
                        n_errors++; $display("FAIL %s write_data got %h exp %h", name, csrWriteData, got);
                    end
                end
            end
            if (csrReadEnable && csrWriteEnable) begin
                n_checks++; n_errors++;
                $display("FAIL %s strobe_overlap got 1 exp 0", name);
            end
            if (resultValid) begin
                seen = 1'b1; res_k = k; instrValid = 1'b0;
            end else begin
                n_checks++;
                if (instrReady !== 1'b0) begin
                    n_errors++; $display("FAIL %s busy_ready got %b exp 0", name, instrReady);
                end
                // Held request with scrambled fields must not disturb the latched instruction.
                instrFunct3 = 3'($urandom); instrAddress = 12'($urandom);
                instrOperand = $urandom; instrRs1 = 5'($urandom); instrRd = 5'($urandom);
            end
        end
        instrValid = 1'b0;

        n_checks++;
        if (!seen) begin
            n_errors++; $display("FAIL %s result_timeout got 0 exp 1", name);
        end
        n_checks++;
        if (res_k != e_lat) begin
            n_errors++; $display("FAIL %s result_latency got %0d exp %0d", name, res_k, e_lat);
        end
        n_checks++;
        if (rd_cnt != e_rd) begin
            n_errors++; $display("FAIL %s read_strobes got %0d exp %0d", name, rd_cnt, e_rd);
        end
        n_checks++;
        if (wr_cnt != e_wr) begin
            n_errors++; $display("FAIL %s write_strobes got %0d exp %0d", name, wr_cnt, e_wr);
        end
        if (e_wr == 1) begin
            n_checks++;
            if (wr_k != 2) begin
                n_errors++; $display("FAIL %s write_cycle got %0d exp 2", name, wr_k);
            end
        end
        n_checks++;
        if (resultData !== e_res) begin
            n_errors++; $display("FAIL %s result_data got %h exp %h", name, resultData, e_res);
        end
        n_checks++;
        if (resultIllegal !== e_ill) begin
            n_errors++; $display("FAIL %s result_illegal got %b exp %b", name, resultIllegal, e_ill);
        end

        hold_d = resultData; hold_i = resultIllegal;
        resultReady = 1'b0;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            n_checks++;
            if (resultValid !== 1'b1 || resultData !== hold_d || resultIllegal !== hold_i ||
                instrReady !== 1'b0 || csrReadEnable || csrWriteEnable) begin
                n_errors++;
                $display("FAIL %s stall_hold got v=%b d=%h i=%b r=%b exp v=1 d=%h i=%b r=0",
                         name, resultValid, resultData, resultIllegal, instrReady, hold_d, hold_i);
            end
        end
        resultReady = 1'b1;
        @(negedge clk);
        resultReady = 1'b0;
        n_checks++;
        if (resultValid !== 1'b0 || instrReady !== 1'b1) begin
            n_errors++;
            $display("FAIL %s release got v=%b r=%b exp v=0 r=1", name, resultValid, instrReady);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; instrValid = 1'b0; instrFunct3 = 3'b0; instrAddress = 12'h0;
        instrOperand = 32'h0; instrRs1 = 5'd0; instrRd = 5'd0; resultReady = 1'b0;
        bus_rd_val = 32'h0; bus_claim = 1'b0; bus_accept = 1'b0;
`ifdef CSR_PRIV_CHECK_EN
        currentPrivilege = 2'b11;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (instrReady !== 1'b1) begin
            n_errors++; $display("FAIL reset_ready got %b exp 1", instrReady);
        end
        n_checks++;
        if ({csrReadEnable, csrWriteEnable, resultValid, resultIllegal} !== 4'b0 ||
            csrReadAddress !== 12'h0 || csrWriteAddress !== 12'h0 ||
            csrWriteData !== 32'h0 || resultData !== 32'h0) begin
            n_errors++; $display("FAIL reset_outputs got re=%b we=%b rv=%b exp all 0",
                                 csrReadEnable, csrWriteEnable, resultValid);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_instr("csrrs_basic", 3'b010, 12'h300, 32'h08, 5'd6, 5'd5, 32'h11, 1'b1, 1'b1, 0);
        run_instr("csrrw_rd0", 3'b001, 12'h340, 32'hDEAD, 5'd6, 5'd0, 32'h55, 1'b1, 1'b1, 0);
        run_instr("csrrci_zimm0", 3'b111, 12'h300, 32'hFFFF_0000, 5'd0, 5'd3, 32'hABCD1234, 1'b1, 1'b1, 1);
        run_instr("csrrc_clear", 3'b011, 12'h305, 32'h0000_00F0, 5'd9, 5'd4, 32'h0000_0FFF, 1'b1, 1'b1, 0);
        run_instr("csrrsi_imm", 3'b110, 12'h341, 32'hFFFF_FFFF, 5'd5, 5'd1, 32'h100, 1'b1, 1'b1, 0);
        run_instr("csrrwi_imm", 3'b101, 12'h342, 32'hFFFF_FFFF, 5'd31, 5'd2, 32'h7, 1'b1, 1'b1, 0);
        run_instr("unclaimed_read", 3'b010, 12'h7FF, 32'h1, 5'd1, 5'd1, 32'h0, 1'b0, 1'b1, 0);
        run_instr("readonly_write", 3'b001, 12'hC00, 32'h1, 5'd2, 5'd1, 32'h42, 1'b1, 1'b1, 0);
        run_instr("write_rejected", 3'b001, 12'h340, 32'h1234, 5'd2, 5'd1, 32'h42, 1'b1, 1'b0, 0);
        run_instr("funct3_000", 3'b000, 12'h300, 32'h1, 5'd1, 5'd1, 32'h42, 1'b1, 1'b1, 0);
        run_instr("funct3_100", 3'b100, 12'h300, 32'h1, 5'd1, 5'd1, 32'h42, 1'b1, 1'b1, 0);
    endtask

    task automatic test_stall();
        run_instr("stall5", 3'b010, 12'h300, 32'h3, 5'd7, 5'd8, 32'hCAFE_0000, 1'b1, 1'b1, 5);
    endtask

    task automatic test_reset_mid_write();
        n_checks++;
        if (instrReady !== 1'b1) begin
            n_errors++; $display("FAIL midrst_accept got %b exp 1", instrReady);
        end
        bus_claim = 1'b1; bus_accept = 1'b1; bus_rd_val = 32'h99;
        instrValid = 1'b1; instrFunct3 = 3'b001; instrAddress = 12'h340;
        instrOperand = 32'h5555; instrRs1 = 5'd3; instrRd = 5'd4;
        @(posedge clk); #1 instrValid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (csrWriteEnable !== 1'b0 || csrReadEnable !== 1'b0 || resultValid !== 1'b0) begin
            n_errors++; $display("FAIL midrst_strobe got we=%b re=%b rv=%b exp 0 0 0",
                                 csrWriteEnable, csrReadEnable, resultValid);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (instrReady !== 1'b1 || resultValid !== 1'b0 || csrWriteEnable || csrReadEnable) begin
                n_errors++; $display("FAIL midrst_idle got r=%b rv=%b exp r=1 rv=0", instrReady, resultValid);
            end
        end
    endtask

`ifdef CSR_PRIV_CHECK_EN
    task automatic test_priv();
        currentPrivilege = 2'b00;
        run_instr("priv_denied", 3'b010, 12'h300, 32'h1, 5'd1, 5'd1, 32'h77, 1'b1, 1'b1, 0);
        currentPrivilege = 2'b11;
        run_instr("priv_granted", 3'b010, 12'h300, 32'h1, 5'd1, 5'd1, 32'h76, 1'b1, 1'b1, 0);
    endtask
`endif

    task automatic test_random();
        logic [4:0] rs1, rd;
        for (int n = 0; n < 40; n++) begin
            rs1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
`ifdef CSR_PRIV_CHECK_EN
            currentPrivilege = 2'($urandom_range(0, 3));
`endif
            run_instr("random", 3'($urandom_range(0, 7)), 12'($urandom), $urandom, rs1, rd,
                      $urandom, ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0),
                      $urandom_range(0, 3));
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_directed();
        test_stall();
        test_reset_mid_write();
`ifdef CSR_PRIV_CHECK_EN
        test_priv();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
